// File: rtl/div_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_mod_pkg
// Description : Shared widths and state encoding for the divider family.
//               The divider and the reconstruct block import this package
//               so their operand widths can never drift apart.
// Revision    : 1.0 - initial release
// ============================================================================
package div_mod_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int QUOTIENT_W = 17;
  localparam int MUL_ITERS  = 16;

  // 17b x 16b magnitude product, plus one sign bit for the signed result
  localparam int ACC_W = QUOTIENT_W + DIVISOR_W;
  localparam int RES_W = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/div_mod_reconstruct_if.sv
`default_nettype none
// ============================================================================
// Module      : div_mod_reconstruct_if
// Description : Operand / result bundle for div_mod_reconstruct.
//               master : drives quotient, divisor, remainder, mode,
//                        valid_input; observes busy, valid_output,
//                        dividend, overflow.
//               slave  : the reconstruct block itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_mod_reconstruct_if;
  import div_mod_pkg::*;

  logic signed [QUOTIENT_W-1:0] quotient;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         mode;
  logic                         valid_input;
  logic                         busy;
  logic                         valid_output;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic                         overflow;

  modport master (
    output quotient, divisor, remainder, mode, valid_input,
    input  busy, valid_output, dividend, overflow
  );

  modport slave (
    input  quotient, divisor, remainder, mode, valid_input,
    output busy, valid_output, dividend, overflow
  );

endinterface
`default_nettype wire

// File: rtl/div_mod_reconstruct.sv
`default_nettype none
// ============================================================================
// Module      : div_mod_reconstruct
// Description : Rebuilds dividend = quotient * divisor (+ remainder) with a
//               serial radix-2 shift-add multiplier. Fixed 18-cycle latency.
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - slave side of div_mod_reconstruct_if (operands, mode,
//           valid_input in; busy, valid_output, dividend, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module div_mod_reconstruct
  import div_mod_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  div_mod_reconstruct_if.slave   bus
);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ACC_W-1:0]        mcand_q, mcand_d;     // |quotient|, shifted left each step
  logic [DIVISOR_W-1:0]    mplier_q, mplier_d;   // |divisor|, shifted right each step
  logic [RES_W-1:0]        acc_q, acc_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic                    mode_q, mode_d;
  logic                    neg_q, neg_d;
  logic [DIVIDEND_W-1:0]   dividend_q, dividend_d;
  logic                    overflow_q, overflow_d;

  logic [QUOTIENT_W-1:0]   q_mag;
  logic [DIVISOR_W-1:0]    d_mag;
  logic [RES_W-1:0]        signed_sum;
  logic [RES_W-DIVIDEND_W:0] res_top;

  // Magnitudes fit unsigned in the operand width, so -65536 and -32768 are exact
  always_comb begin
    q_mag = bus.quotient[QUOTIENT_W-1] ? -bus.quotient : bus.quotient;
    d_mag = bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;
  end

  always_comb begin
    signed_sum = neg_q ? ({RES_W{1'b0}} - acc_q) : acc_q;
    if (!mode_q) begin
      signed_sum = signed_sum + {{(RES_W-DIVISOR_W){rem_q[DIVISOR_W-1]}}, rem_q};
    end
  end

  // Representable in 32-bit signed only when bits 33..31 are all equal
  assign res_top = acc_q[RES_W-1:DIVIDEND_W-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    neg_d      = neg_q;
    dividend_d = dividend_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_input) begin
          state_d  = ST_MUL;
          cnt_d    = 4'd0;
          acc_d    = '0;
          mcand_d  = {{(ACC_W-QUOTIENT_W){1'b0}}, q_mag};
          mplier_d = d_mag;
          rem_d    = bus.remainder;
          mode_d   = bus.mode;
          neg_d    = bus.quotient[QUOTIENT_W-1] ^ bus.divisor[DIVISOR_W-1];
        end
      end

      ST_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + {1'b0, mcand_q};
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Counter wraps back to zero on the last step, ready for ADD
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'(MUL_ITERS - 1)) begin
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        // First ADD cycle forms the signed sum; second commits it to the outputs
        if (cnt_q == 4'd0) begin
          acc_d = signed_sum;
          cnt_d = 4'd1;
        end else begin
          dividend_d = acc_q[DIVIDEND_W-1:0];
          overflow_d = !((&res_top) || (~|res_top));
          cnt_d      = 4'd0;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      neg_q      <= 1'b0;
      dividend_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      neg_q      <= neg_d;
      dividend_q <= dividend_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.valid_output = (state_q == ST_DONE);
  assign bus.dividend     = dividend_q;
  assign bus.overflow     = overflow_q;

endmodule
`default_nettype wire

// File: doc/div_mod_reconstruct.md
DIV_MOD_RECONSTRUCT -- requirements
Module: div_mod_reconstruct

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-low reset.
REQ-003 Port quotient, input, 17, signed: multiplicand, same width as the divider's final_output.
REQ-004 Port divisor, input, 16, signed: multiplier.
REQ-005 Port remainder, input, 16, signed: addend.
REQ-006 Port mode, input, 1: 1 = product only; 0 = product plus remainder.
REQ-007 Port valid_input, input, 1: operands and mode valid this cycle.
REQ-008 Port busy, output, 1: high whenever the state is not IDLE.
REQ-009 Port valid_output, output, 1: one-cycle result strobe.
REQ-010 Port dividend, output, 32, signed: reconstructed value.
REQ-011 Port overflow, output, 1: true result not representable in 32-bit signed.

Function
REQ-012 FSM states: IDLE, MUL, ADD, DONE; IDLE->MUL on valid_input=1; MUL->ADD after 16 iterations; ADD->DONE; DONE->IDLE unconditionally.
REQ-013 Accept edge N: in IDLE with valid_input=1, latch quotient, divisor, remainder and mode; zero the accumulator; zero the 4-bit iteration counter.
REQ-014 MUL, edges N+1..N+16: radix-2 shift-add on the two's-complement magnitudes (|quotient| 17b, |divisor| 16b) into a 33-bit unsigned accumulator; one multiplier bit per edge, LSB first.
REQ-015 ADD, edge N+17: negate the accumulator if the operand signs differ; if latched mode=0, add sign-extended remainder; all arithmetic 34-bit signed.
REQ-016 overflow = 1 iff the 34-bit result lies outside [-2^31, 2^31-1]; dividend = low 32 bits of the result (wrap).
REQ-017 DONE is entered at edge N+18; valid_output=1, dividend and overflow valid only in that cycle; valid_output=0 in all other states.
REQ-018 dividend and overflow hold their last value until the next DONE.
REQ-019 valid_input is ignored while busy=1 and has no queueing; the earliest next accept is edge N+20.
REQ-020 Operand changes after edge N have no effect on the result in progress.
REQ-021 Zero operand: the full 16 iterations still run; fixed latency of 18 cycles regardless of operand values.
REQ-022 Most-negative operands (-65536, -32768) are handled exactly via the 33-bit magnitude path; no saturation.

Reset
REQ-023 reset=0 forces IDLE immediately, independent of clk; busy=0, valid_output=0, dividend=0, overflow=0; counter and operand registers cleared.
REQ-024 Reset mid-operation discards the operation in progress; valid_output is never issued for it.
REQ-025 After reset deassertion, the first accept is possible at the first rising edge with valid_input=1.

Structure
REQ-026 Shared package div_mod_pkg holds DIVIDEND_W=32, DIVISOR_W=16, QUOTIENT_W=17, the MUL iteration count, and the state enumeration, so the divider and this block share the same widths.
REQ-027 Single module; no sub-module. The datapath is one accumulator, one shifter, one adder/negator, and a 4-bit counter.
REQ-028 The RTL is synthesizable; no multiply operator, no latches.

Verification
REQ-029 mode=0, quotient=26, divisor=-3, remainder=-2 -> dividend=-80, overflow=0, valid_output exactly at cycle N+18.
REQ-030 mode=1, quotient=26, divisor=-3, remainder=-2 -> dividend=-78 (remainder ignored).
REQ-031 mode=1, quotient=-65536, divisor=-32768 -> overflow=1, dividend=0x80000000; then quotient=65535, divisor=32767 -> dividend=2147385345, overflow=0.
REQ-032 valid_input held high for 40 cycles -> exactly two accepts, at edges N and N+20, and two single-cycle valid_output pulses; operands changed during busy do not alter the results.
REQ-033 reset pulsed low at cycle N+9 -> busy=0 and all outputs 0 immediately; no valid_output for the aborted operation; the next operation computes correctly.
REQ-034 Loopback: drive the divider with dividend=-80, divisor=-3 in both modes; feed quotient/remainder here -> reconstructed dividend equals -80.
